// File: rtl/cle_unpack_label_if.sv
// Handshake, pattern-ROM and label-SRAM signals between cle_unpack_label and its environment.
interface cle_unpack_label_if #(
    parameter int ROM_W   = 8,
    parameter int ROM_AW  = 7,
    parameter int SRAM_AW = 10,
    parameter int LBL_W   = 8
);
    logic               start;
    logic               mode;
    logic [ROM_AW-1:0]  rom_a;
    logic [ROM_W-1:0]   rom_q;
    logic [SRAM_AW-1:0] sram_a;
    logic [LBL_W-1:0]   sram_d;
    logic               sram_wen;
    logic               busy;
    logic               finish;
    logic               label_ovf;

    // Environment side: issues start/mode and returns ROM data.
    modport master (
        output start, mode, rom_q,
        input  rom_a, sram_a, sram_d, sram_wen, busy, finish, label_ovf
    );

    // Unpacker side.
    modport slave (
        input  start, mode, rom_q,
        output rom_a, sram_a, sram_d, sram_wen, busy, finish, label_ovf
    );
endinterface

// File: rtl/cle_unpack_label.sv
// Expands a packed ROM image into one SRAM word per pixel, either as a raw
// copy (mode 0) or as first-pass 4-connectivity provisional labels (mode 1).
module cle_unpack_label #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int ROM_W   = 8,
    parameter int ROM_AW  = 7,
    parameter int SRAM_AW = 10,
    parameter int LBL_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    cle_unpack_label_if.slave bus
);
    localparam int NWORDS = IMG_W * IMG_H / ROM_W;
    localparam int KW     = (ROM_W > 1) ? $clog2(ROM_W) : 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [ROM_AW-1:0] LAST_W  = ROM_AW'(NWORDS - 1);
    localparam logic [KW-1:0]     LAST_K  = KW'(ROM_W - 1);
    localparam logic [CW-1:0]     LAST_C  = CW'(IMG_W - 1);
    localparam logic [LBL_W-1:0]  MAX_LBL = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_EMIT, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic               r_mode, r_busy, r_finish, r_ovf;
    logic               r_max_used;   // top label value already handed out once
    logic               r_first_row;
    logic [ROM_AW-1:0]  r_w;
    logic [KW-1:0]      r_k;
    logic [ROM_W-1:0]   r_shift;
    logic [SRAM_AW-1:0] r_pix;
    logic [CW-1:0]      r_col;
    logic [LBL_W-1:0]   r_left;
    logic [LBL_W-1:0]   r_next_label;
    logic [LBL_W-1:0]   r_linebuf [IMG_W];

    logic               w_accept, w_emit, w_pixel, w_new;
    logic [LBL_W-1:0]   w_up, w_label;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_emit   = (r_state == S_EMIT);
    assign w_pixel  = r_shift[ROM_W-1];
    // Row 0 has no pixel above it; the line buffer is also cleared at start.
    assign w_up     = r_first_row ? '0 : r_linebuf[r_col];
    assign w_new    = w_pixel && (r_left == '0) && (w_up == '0);

    // Provisional label for the current pixel from its left and upper neighbours.
    always_comb begin
        w_label = '0;
        if (w_pixel) begin
            if (w_new)
                w_label = r_next_label;
            else if (r_left == '0)
                w_label = w_up;
            else if (w_up == '0)
                w_label = r_left;
            else
                w_label = (r_left < w_up) ? r_left : w_up;
        end
    end

    // Next-state logic: fetch, latch, then emit ROM_W pixels per word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_LATCH;
            S_LATCH: w_state_next = S_EMIT;
            S_EMIT:  if (r_k == LAST_K) w_state_next = (r_w == LAST_W) ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus run counters, shift register and label bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
            r_ovf        <= 1'b0;
            r_max_used   <= 1'b0;
            r_first_row  <= 1'b1;
            r_w          <= '0;
            r_k          <= '0;
            r_shift      <= '0;
            r_pix        <= '0;
            r_col        <= '0;
            r_left       <= '0;
            r_next_label <= LBL_W'(1);
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode       <= bus.mode;
                        r_finish     <= 1'b0;
                        r_ovf        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_max_used   <= 1'b0;
                        r_first_row  <= 1'b1;
                        r_w          <= '0;
                        r_pix        <= '0;
                        r_col        <= '0;
                        r_left       <= '0;
                        r_next_label <= LBL_W'(1);
                    end
                end
                S_LATCH: begin
                    r_shift <= bus.rom_q;
                    r_k     <= '0;
                end
                S_EMIT: begin
                    r_shift <= r_shift << 1;
                    r_k     <= r_k + KW'(1);
                    r_pix   <= r_pix + SRAM_AW'(1);
                    if (r_col == LAST_C) begin
                        r_col       <= '0;
                        r_first_row <= 1'b0;
                        r_left      <= '0;
                    end else begin
                        r_col  <= r_col + CW'(1);
                        r_left <= w_label;
                    end
                    // The top label is valid once; a second request for it means
                    // the label space has run out.
                    if (r_mode && w_new) begin
                        if (r_next_label != MAX_LBL)
                            r_next_label <= r_next_label + LBL_W'(1);
                        else if (r_max_used)
                            r_ovf <= 1'b1;
                        else
                            r_max_used <= 1'b1;
                    end
                    if (r_k == LAST_K) begin
                        if (r_w == LAST_W) begin
                            r_busy   <= 1'b0;
                            r_finish <= 1'b1;
                        end else begin
                            r_w <= r_w + ROM_AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer: previous row's labels, cleared at every accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_W; i++) r_linebuf[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < IMG_W; i++) r_linebuf[i] <= '0;
        end else if (w_emit && r_mode) begin
            r_linebuf[r_col] <= w_label;
        end
    end

    assign bus.rom_a     = r_w;
    assign bus.sram_a    = r_pix;
    assign bus.sram_wen  = ~w_emit;
    assign bus.sram_d    = w_emit ? (r_mode ? w_label : LBL_W'(w_pixel)) : '0;
    assign bus.busy      = r_busy;
    assign bus.finish    = r_finish;
    assign bus.label_ovf = r_ovf;
endmodule

// File: tb/tb_cle_unpack_label.sv
// Bench for cle_unpack_label: two instances (8-bit and 2-bit labels) against a
// behavioural ROM/SRAM and a row-major labelling reference model.
module tb_cle_unpack_label;
    localparam int IMG_W   = 32;
    localparam int IMG_H   = 32;
    localparam int ROM_W   = 8;
    localparam int ROM_AW  = 7;
    localparam int SRAM_AW = 10;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int NWORDS  = NPIX / ROM_W;
    localparam int RUN_CYC = NWORDS * (ROM_W + 2) + 1;
    localparam logic [28:0] RST_VEC_A = {7'd0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [22:0] RST_VEC_B = {7'd0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cle_unpack_label_if #(.ROM_W(ROM_W), .ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .LBL_W(8)) bus_a ();
    cle_unpack_label_if #(.ROM_W(ROM_W), .ROM_AW(ROM_AW), .SRAM_AW(SRAM_AW), .LBL_W(2)) bus_b ();

    cle_unpack_label #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ROM_W(ROM_W), .ROM_AW(ROM_AW),
                       .SRAM_AW(SRAM_AW), .LBL_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    cle_unpack_label #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ROM_W(ROM_W), .ROM_AW(ROM_AW),
                       .SRAM_AW(SRAM_AW), .LBL_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;

    logic [ROM_W-1:0] rom_mem [NWORDS];
    logic [7:0]       mem_a [NPIX];
    int               rel_a [NPIX];
    int               nwr_a = 0;
    logic [1:0]       mem_b [NPIX];
    logic             ovf_wr_b [NPIX];
    int               nwr_b = 0;

    int exp_lbl [NPIX];
    bit exp_ovf_wr [NPIX];
    bit exp_ovf_end;

    // Synchronous pattern ROM shared by both instances; free-running cycle count.
    always @(posedge clk) begin
        cyc++;
        bus_a.rom_q <= rom_mem[bus_a.rom_a];
        bus_b.rom_q <= rom_mem[bus_b.rom_a];
    end

    // SRAM model: capture each write while the bus is stable mid-cycle.
    always @(negedge clk) begin
        if (bus_a.sram_wen === 1'b0) begin
            mem_a[bus_a.sram_a] = bus_a.sram_d;
            rel_a[bus_a.sram_a] = cyc - t0;
            nwr_a++;
        end
        if (bus_b.sram_wen === 1'b0) begin
            mem_b[bus_b.sram_a]    = bus_b.sram_d;
            ovf_wr_b[bus_b.sram_a] = bus_b.label_ovf;
            nwr_b++;
        end
    end

    function automatic bit pix(input int p);
        logic [ROM_W-1:0] w;
        w = rom_mem[p / ROM_W];
        return w[ROM_W-1 - (p % ROM_W)];
    endfunction

    // Reference: scan pixels row-major, labelling from already-labelled neighbours.
    task automatic build_model(input bit md, input int lmax);
        int ncomp = 0;
        int l, u;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                int p = r * IMG_W + c;
                exp_ovf_wr[p] = (ncomp > lmax);
                if (!md)           exp_lbl[p] = int'(pix(p));
                else if (!pix(p))  exp_lbl[p] = 0;
                else begin
                    l = (c > 0) ? exp_lbl[p-1] : 0;
                    u = (r > 0) ? exp_lbl[p-IMG_W] : 0;
                    if (l == 0 && u == 0) begin
                        ncomp++;
                        exp_lbl[p] = (ncomp < lmax) ? ncomp : lmax;
                    end else if (l == 0)   exp_lbl[p] = u;
                    else if (u == 0)       exp_lbl[p] = l;
                    else                   exp_lbl[p] = (l < u) ? l : u;
                end
            end
        end
        exp_ovf_end = (ncomp > lmax);
    endtask

    // Drive one run on instance A; optionally pulse start mid-run. lat = -1 on timeout.
    task automatic run_a(input bit md, input bit disturb, output int lat);
        nwr_a = 0;
        for (int p = 0; p < NPIX; p++) rel_a[p] = -1;
        @(negedge clk);
        t0 = cyc; bus_a.mode = md; bus_a.start = 1'b1;
        lat = -1;
        for (int i = 1; i <= RUN_CYC + 50; i++) begin
            @(negedge clk);
            bus_a.start = 1'b0; bus_a.mode = md;
            if (disturb && (i == 5 || i == 700)) begin
                bus_a.start = 1'b1; bus_a.mode = ~md;
            end
            if (bus_a.finish === 1'b1) begin lat = i; break; end
        end
        bus_a.start = 1'b0;
    endtask

    task automatic run_b(input bit md, output int lat);
        nwr_b = 0;
        @(negedge clk);
        t0 = cyc; bus_b.mode = md; bus_b.start = 1'b1;
        lat = -1;
        for (int i = 1; i <= RUN_CYC + 50; i++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.finish === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus_a.rom_a, bus_a.sram_a, bus_a.sram_d, bus_a.sram_wen, bus_a.busy, bus_a.finish,
             bus_a.label_ovf} !== RST_VEC_A) begin
            n_err++; $display("FAIL reset_a: got %h want %h", {bus_a.rom_a, bus_a.sram_a, bus_a.sram_d,
                bus_a.sram_wen, bus_a.busy, bus_a.finish, bus_a.label_ovf}, RST_VEC_A);
        end
        n_cmp++;
        if ({bus_b.rom_a, bus_b.sram_a, bus_b.sram_d, bus_b.sram_wen, bus_b.busy, bus_b.finish,
             bus_b.label_ovf} !== RST_VEC_B) begin
            n_err++; $display("FAIL reset_b: got %h want %h", {bus_b.rom_a, bus_b.sram_a, bus_b.sram_d,
                bus_b.sram_wen, bus_b.busy, bus_b.finish, bus_b.label_ovf}, RST_VEC_B);
        end
        $display("test_reset: outputs of both instances checked under reset");
    endtask

    task automatic test_copy();
        int lat;
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = 8'(n);
        build_model(1'b0, 255);
        run_a(1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== RUN_CYC) begin n_err++; $display("FAIL copy_latency: got %0d want %0d", lat, RUN_CYC); end
        n_cmp++;
        if (nwr_a !== NPIX) begin n_err++; $display("FAIL copy_writes: got %0d want %0d", nwr_a, NPIX); end
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_a[p] !== 8'(exp_lbl[p])) begin
                n_err++; $display("FAIL copy_data[%0d]: got %0d want %0d", p, mem_a[p], exp_lbl[p]);
            end
            n_cmp++;
            if (rel_a[p] !== (p / ROM_W) * (ROM_W + 2) + 3 + p % ROM_W) begin
                n_err++; $display("FAIL copy_wr_cycle[%0d]: got %0d want %0d", p, rel_a[p],
                                  (p / ROM_W) * (ROM_W + 2) + 3 + p % ROM_W);
            end
        end
        $display("test_copy: mode 0 counting image, latency %0d", lat);
    endtask

    task automatic test_ones();
        int lat;
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = 8'hFF;
        build_model(1'b1, 255);
        run_a(1'b1, 1'b0, lat);
        n_cmp++;
        if (lat !== RUN_CYC) begin n_err++; $display("FAIL ones_latency: got %0d want %0d", lat, RUN_CYC); end
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_a[p] !== 8'd1) begin n_err++; $display("FAIL ones_data[%0d]: got %0d want 1", p, mem_a[p]); end
        end
        n_cmp++;
        if (bus_a.label_ovf !== 1'b0) begin n_err++; $display("FAIL ones_ovf: got %b want 0", bus_a.label_ovf); end
        $display("test_ones: mode 1 all-ones image");
    endtask

    task automatic test_bridge();
        int lat;
        int spots [20];
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = '0;
        spots = '{0, 1, 32, 33, 10, 11, 42, 43, 64, 65, 66, 67, 68, 69, 70, 71, 72, 73, 74, 75};
        for (int i = 0; i < 20; i++) rom_mem[spots[i] / ROM_W][ROM_W-1 - spots[i] % ROM_W] = 1'b1;
        build_model(1'b1, 255);
        run_a(1'b1, 1'b0, lat);
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_a[p] !== 8'(exp_lbl[p])) begin
                n_err++; $display("FAIL bridge_data[%0d]: got %0d want %0d", p, mem_a[p], exp_lbl[p]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (mem_a[spots[i]] !== ((i >= 4 && i < 8) ? 8'd2 : 8'd1)) begin
                n_err++; $display("FAIL bridge_spot[%0d]: got %0d want %0d", spots[i], mem_a[spots[i]],
                                  (i >= 4 && i < 8) ? 2 : 1);
            end
        end
        $display("test_bridge: two blobs joined by a row-2 bridge");
    endtask

    task automatic test_overflow();
        int lat;
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = ((n / (IMG_W / ROM_W)) % 2 == 0) ? 8'hAA : 8'h55;
        build_model(1'b1, 3);
        run_b(1'b1, lat);
        n_cmp++;
        if (lat !== RUN_CYC) begin n_err++; $display("FAIL ovf_latency: got %0d want %0d", lat, RUN_CYC); end
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_b[p] !== 2'(exp_lbl[p]) || ovf_wr_b[p] !== exp_ovf_wr[p]) begin
                n_err++; $display("FAIL ovf_pixel[%0d]: got lbl %0d ovf %b want lbl %0d ovf %b", p, mem_b[p],
                                  ovf_wr_b[p], exp_lbl[p], exp_ovf_wr[p]);
            end
        end
        n_cmp++;
        if ({mem_b[0], mem_b[2], mem_b[4], mem_b[6]} !== {2'd1, 2'd2, 2'd3, 2'd3}) begin
            n_err++; $display("FAIL ovf_first_labels: got %0d %0d %0d %0d want 1 2 3 3",
                              mem_b[0], mem_b[2], mem_b[4], mem_b[6]);
        end
        n_cmp++;
        if (ovf_wr_b[6] !== 1'b0 || ovf_wr_b[8] !== 1'b1) begin
            n_err++; $display("FAIL ovf_rise: got %b,%b around 4th component want 0,1", ovf_wr_b[6], ovf_wr_b[8]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_b.label_ovf, bus_b.finish} !== 2'b11) begin
            n_err++; $display("FAIL ovf_sticky: got ovf %b finish %b want 1 1", bus_b.label_ovf, bus_b.finish);
        end
        $display("test_overflow: 2-bit labels on a checkerboard");
    endtask

    task automatic test_random();
        int lat;
        for (int it = 0; it < 2; it++) begin
            for (int n = 0; n < NWORDS; n++) rom_mem[n] = 8'($urandom);
            build_model(it[0], 255);
            run_a(it[0], 1'b0, lat);
            n_cmp++;
            if (lat !== RUN_CYC) begin n_err++; $display("FAIL rand_latency: got %0d want %0d", lat, RUN_CYC); end
            for (int p = 0; p < NPIX; p++) begin
                n_cmp++;
                if (mem_a[p] !== 8'(exp_lbl[p])) begin
                    n_err++; $display("FAIL rand_data[%0d] mode %0d: got %0d want %0d", p, it, mem_a[p], exp_lbl[p]);
                end
            end
            n_cmp++;
            if (bus_a.label_ovf !== exp_ovf_end) begin
                n_err++; $display("FAIL rand_ovf mode %0d: got %b want %b", it, bus_a.label_ovf, exp_ovf_end);
            end
            $display("test_random: mode %0d random image", it);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = 8'($urandom);
        build_model(1'b0, 255);
        @(negedge clk);
        t0 = cyc; bus_a.mode = 1'b0; bus_a.start = 1'b1;
        for (int i = 1; i <= 405; i++) begin @(negedge clk); bus_a.start = 1'b0; end
        n_cmp++;
        if ({bus_a.sram_wen, bus_a.busy} !== 2'b01) begin
            n_err++; $display("FAIL midrun_emit: got wen %b busy %b want 0 1", bus_a.sram_wen, bus_a.busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus_a.rom_a, bus_a.sram_a, bus_a.sram_d, bus_a.sram_wen, bus_a.busy, bus_a.finish,
             bus_a.label_ovf} !== RST_VEC_A) begin
            n_err++; $display("FAIL midrun_async_reset: got %h want %h", {bus_a.rom_a, bus_a.sram_a,
                bus_a.sram_d, bus_a.sram_wen, bus_a.busy, bus_a.finish, bus_a.label_ovf}, RST_VEC_A);
        end
        @(negedge clk);
        reset = 1'b0;
        run_a(1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== RUN_CYC) begin n_err++; $display("FAIL rerun_latency: got %0d want %0d", lat, RUN_CYC); end
        n_cmp++;
        if (nwr_a !== NPIX) begin n_err++; $display("FAIL rerun_writes: got %0d want %0d", nwr_a, NPIX); end
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_a[p] !== 8'(exp_lbl[p])) begin
                n_err++; $display("FAIL rerun_data[%0d]: got %0d want %0d", p, mem_a[p], exp_lbl[p]);
            end
        end
        $display("test_reset_midrun: reset in word 40, then full copy");
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int n = 0; n < NWORDS; n++) rom_mem[n] = 8'(n);
        build_model(1'b0, 255);
        run_a(1'b0, 1'b1, lat);
        n_cmp++;
        if (lat !== RUN_CYC) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, RUN_CYC); end
        for (int p = 0; p < NPIX; p++) begin
            n_cmp++;
            if (mem_a[p] !== 8'(exp_lbl[p])) begin
                n_err++; $display("FAIL b2b_data[%0d]: got %0d want %0d", p, mem_a[p], exp_lbl[p]);
            end
        end
        // Start presented during the finishing cycle must be ignored.
        bus_a.start = 1'b1; bus_a.mode = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        n_cmp++;
        if ({bus_a.busy, bus_a.finish} !== 2'b01) begin
            n_err++; $display("FAIL done_start_ignored: got busy %b finish %b want 0 1", bus_a.busy, bus_a.finish);
        end
        nwr_a = 0;
        t0 = cyc; bus_a.start = 1'b1; bus_a.mode = 1'b0;
        @(negedge clk);
        bus_a.start = 1'b0;
        n_cmp++;
        if ({bus_a.busy, bus_a.finish} !== 2'b10) begin
            n_err++; $display("FAIL restart_accept: got busy %b finish %b want 1 0", bus_a.busy, bus_a.finish);
        end
        lat = -1;
        for (int i = 2; i <= RUN_CYC + 50; i++) begin
            @(negedge clk);
            if (bus_a.finish === 1'b1) begin lat = i; break; end
        end
        n_cmp++;
        if (lat !== RUN_CYC || nwr_a !== NPIX) begin
            n_err++; $display("FAIL restart_run: got latency %0d writes %0d want %0d %0d", lat, nwr_a, RUN_CYC, NPIX);
        end
        $display("test_back_to_back: mid-run starts ignored, restart after finish");
    endtask

    initial begin
        reset = 1'b1;
        bus_a.start = 1'b0; bus_a.mode = 1'b0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_copy();
        test_ones();
        test_bridge();
        test_overflow();
        test_random();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
